// File: rtl/ifu_fetch_buffer.sv
// Instruction-fetch front end: one-outstanding word fetch, slot split into a FIFO, redirect flush.
// Optional perf counters: define IFU_PERF_EN to add perf_fetch_cnt / perf_stall_cnt.
module ifu_fetch_buffer #(
  parameter int ADDR_W = 64,
  parameter int DATA_W = 64,
  parameter int INST_W = 32,
  parameter int DEPTH  = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = 'h8000_0000
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          redirect_valid,
  input  logic [ADDR_W-1:0]             redirect_pc,
  output logic                          mem_req_valid,
  input  logic                          mem_req_ready,
  output logic [ADDR_W-1:0]             mem_req_addr,
  input  logic                          mem_resp_valid,
  input  logic [DATA_W-1:0]             mem_resp_data,
  output logic                          inst_valid,
  input  logic                          inst_ready,
  output logic [INST_W-1:0]             inst,
  output logic [ADDR_W-1:0]             inst_pc,
  output logic [2:0]                    dbg_state,
  output logic [$clog2(DEPTH+1)-1:0]    dbg_count
`ifdef IFU_PERF_EN
  ,
  output logic [31:0]                   perf_fetch_cnt,
  output logic [31:0]                   perf_stall_cnt
`endif
);

  localparam int SLOTS = DATA_W / INST_W;
  localparam int IB    = $clog2(INST_W / 8);
  localparam int WB    = $clog2(DATA_W / 8);
  localparam int SW    = $clog2(SLOTS) + 1;
  localparam int PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW    = $clog2(DEPTH + 1);
  localparam logic [ADDR_W-1:0] WMASK = ~((ADDR_W'(1) << WB) - ADDR_W'(1));
  localparam logic [ADDR_W-1:0] IMASK = ~((ADDR_W'(1) << IB) - ADDR_W'(1));

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_REQ       = 3'd1,
    S_WAIT      = 3'd2,
    S_REQ_STALE = 3'd3,
    S_DROP      = 3'd4
  } state_t;

  state_t              state;
  logic [ADDR_W-1:0]   fetch_pc;
  logic [ADDR_W-1:0]   req_addr;
  logic [PW-1:0]       wptr, rptr;
  logic [CW-1:0]       count, free;
  logic [SW-1:0]       off, need, n_push;
  logic                push_en, pop, fits;
  logic [INST_W-1:0]   fifo_inst [DEPTH];
  logic [ADDR_W-1:0]   fifo_pc   [DEPTH];

  // Handshakes: a transfer happens on a rising edge where valid and ready are both high;
  // a raised mem_req_valid holds its address until accepted, responses are always accepted.
  assign off     = SW'((fetch_pc & ~WMASK) >> IB);
  assign need    = SW'(SLOTS) - off;
  assign free    = CW'(DEPTH) - count;
  assign fits    = 32'(need) <= 32'(free);
  assign push_en = (state == S_WAIT) && mem_resp_valid && !redirect_valid;
  assign n_push  = push_en ? need : '0;
  assign pop     = inst_valid && inst_ready;

  assign inst_valid   = (count != '0);
  assign inst         = fifo_inst[rptr];
  assign inst_pc      = fifo_pc[rptr];
  assign mem_req_addr = req_addr;
  assign dbg_state    = state;
  assign dbg_count    = count;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state         <= S_IDLE;
      fetch_pc      <= RESET_PC;
      req_addr      <= '0;
      mem_req_valid <= 1'b0;
      wptr          <= '0;
      rptr          <= '0;
      count         <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        fifo_inst[i] <= '0;
        fifo_pc[i]   <= '0;
      end
    end else if (redirect_valid) begin
      // Flush wins over any same-cycle pop; the in-flight request is left to drain as stale.
      fetch_pc <= redirect_pc & IMASK;
      wptr     <= '0;
      rptr     <= '0;
      count    <= '0;
      case (state)
        S_REQ: begin
          if (mem_req_ready) begin
            state         <= S_DROP;
            mem_req_valid <= 1'b0;
          end else begin
            state <= S_REQ_STALE;
          end
        end
        S_WAIT:      state <= mem_resp_valid ? S_IDLE : S_DROP;
        S_REQ_STALE: begin
          if (mem_req_ready) begin
            state         <= S_DROP;
            mem_req_valid <= 1'b0;
          end
        end
        S_DROP:      if (mem_resp_valid) state <= S_IDLE;
        default:     state <= state;
      endcase
    end else begin
      case (state)
        S_IDLE: begin
          if (fits) begin
            state         <= S_REQ;
            mem_req_valid <= 1'b1;
            req_addr      <= fetch_pc & WMASK;
          end
        end
        S_REQ: begin
          if (mem_req_ready) begin
            state         <= S_WAIT;
            mem_req_valid <= 1'b0;
          end
        end
        S_WAIT: begin
          if (mem_resp_valid) begin
            state    <= S_IDLE;
            fetch_pc <= req_addr + ADDR_W'(DATA_W / 8);
          end
        end
        S_REQ_STALE: begin
          if (mem_req_ready) begin
            state         <= S_DROP;
            mem_req_valid <= 1'b0;
          end
        end
        S_DROP:  if (mem_resp_valid) state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
      // Slots below the fetch offset precede the target PC and are skipped.
      if (push_en) begin
        for (int k = 0; k < SLOTS; k++) begin
          if (k >= int'(off)) begin
            fifo_inst[PW'((int'(wptr) + k - int'(off)) % DEPTH)] <= mem_resp_data[k*INST_W +: INST_W];
            fifo_pc[PW'((int'(wptr) + k - int'(off)) % DEPTH)]   <= req_addr + ADDR_W'(k * (INST_W / 8));
          end
        end
      end
      wptr  <= PW'((int'(wptr) + int'(n_push)) % DEPTH);
      rptr  <= PW'((int'(rptr) + (pop ? 1 : 0)) % DEPTH);
      count <= count + CW'(n_push) - CW'(pop);
    end
  end

`ifdef IFU_PERF_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      perf_fetch_cnt <= '0;
      perf_stall_cnt <= '0;
    end else begin
      if (push_en)     perf_fetch_cnt <= perf_fetch_cnt + 32'd1;
      if (!inst_valid) perf_stall_cnt <= perf_stall_cnt + 32'd1;
    end
  end
`endif

endmodule
